// File: rtl/branch_history_table_pkg.sv
// Shared constants for the branch history table: default widths, PC field
// positions and the 2-bit saturating counter encodings.
package branch_history_table_pkg;

  localparam int BHT_PC_WIDTH    = 32;
  localparam int BHT_INDEX_WIDTH = 6;
  localparam int BHT_TAG_WIDTH   = 8;
  localparam int BHT_CNT_WIDTH   = 32;
  // Instructions are word aligned, so the index starts above PC[1:0].
  localparam int BHT_INDEX_LSB   = 2;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t STRONG_NT = 2'b00;
  localparam bht_ctr_t WEAK_NT   = 2'b01;
  localparam bht_ctr_t WEAK_T    = 2'b10;
  localparam bht_ctr_t STRONG_T  = 2'b11;
  localparam bht_ctr_t CTR_RESET = WEAK_NT;

endpackage

// File: rtl/branch_history_table_sat_counter.sv
// 2-bit saturating counter next-state function used on the table update path.
module bht_sat_counter
  import branch_history_table_pkg::*;
(
  input  bht_ctr_t ctr,
  input  logic     taken,
  output bht_ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != STRONG_T) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != STRONG_NT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_history_table.sv
// Tagged, direct-mapped branch history table with zero-latency lookup and
// registered EX-stage update. Define BHT_GSHARE_EN to XOR a global history into the index.
module branch_history_table
  import branch_history_table_pkg::*;
#(
  parameter int PC_WIDTH    = BHT_PC_WIDTH,
  parameter int INDEX_WIDTH = BHT_INDEX_WIDTH,
  parameter int TAG_WIDTH   = BHT_TAG_WIDTH,
  parameter int CNT_WIDTH   = BHT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_WIDTH-1:0]  if_pc,
  output logic                 pred_taken,
  output logic [PC_WIDTH-1:0]  pred_target,
  input  logic                 upd_valid,
  input  logic [PC_WIDTH-1:0]  upd_pc,
  input  logic                 upd_taken,
  input  logic [PC_WIDTH-1:0]  upd_target,
  input  logic                 upd_mispredict,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam int TAG_LSB = BHT_INDEX_LSB + INDEX_WIDTH;
  localparam int TAG_MSB = TAG_LSB + TAG_WIDTH - 1;

  logic                valid_q  [ENTRIES];
  logic                valid_d  [ENTRIES];
  logic [TAG_WIDTH-1:0] tag_q   [ENTRIES];
  logic [TAG_WIDTH-1:0] tag_d   [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];
  logic [PC_WIDTH-1:0] target_d [ENTRIES];
  bht_ctr_t            ctr_q    [ENTRIES];
  bht_ctr_t            ctr_d    [ENTRIES];

  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

  logic [INDEX_WIDTH-1:0] if_idx, upd_idx;
  logic [TAG_WIDTH-1:0]   if_tag, upd_tag;
  logic                   if_hit, upd_hit;
  bht_ctr_t               upd_ctr_next;

  assign if_tag  = if_pc[TAG_MSB:TAG_LSB];
  assign upd_tag = upd_pc[TAG_MSB:TAG_LSB];

`ifdef BHT_GSHARE_EN
  logic [INDEX_WIDTH-1:0] ghr_q, ghr_d;

  assign if_idx  = if_pc[TAG_LSB-1:BHT_INDEX_LSB] ^ ghr_q;
  assign upd_idx = upd_pc[TAG_LSB-1:BHT_INDEX_LSB] ^ ghr_q;

  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid) ghr_d = {ghr_q[INDEX_WIDTH-2:0], upd_taken};
  end

  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end
`else
  assign if_idx  = if_pc[TAG_LSB-1:BHT_INDEX_LSB];
  assign upd_idx = upd_pc[TAG_LSB-1:BHT_INDEX_LSB];
`endif

  // Low alignment bits and PC bits above the tag do not take part in lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[BHT_INDEX_LSB-1:0], if_pc[PC_WIDTH-1:TAG_MSB+1],
                            upd_pc[BHT_INDEX_LSB-1:0], upd_pc[PC_WIDTH-1:TAG_MSB+1]};

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? target_q[if_idx] : '0;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  bht_sat_counter u_sat_counter (
    .ctr      (ctr_q[upd_idx]),
    .taken    (upd_taken),
    .ctr_next (upd_ctr_next)
  );

  always_comb begin
    valid_d            = valid_q;
    tag_d              = tag_q;
    target_d           = target_q;
    ctr_d              = ctr_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (upd_valid) begin
      branch_count_d = branch_count_q + CNT_WIDTH'(1);
      if (upd_mispredict) mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
      if (upd_hit) begin
        ctr_d[upd_idx] = upd_ctr_next;
        if (upd_taken) target_d[upd_idx] = upd_target;
      end else if (upd_taken) begin
        // Taken miss evicts whatever branch aliased onto this index.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = WEAK_T;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      valid_q            <= valid_d;
      tag_q              <= tag_d;
      target_q           <= target_d;
      ctr_q              <= ctr_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table (default build, no gshare):
// table-driven predict/update vectors plus reset and counter-wrap sequences.
module tb_branch_history_table;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  logic        c4_pred_taken;
  logic [31:0] c4_pred_target;
  logic [3:0]  c4_branch_count;
  logic [3:0]  c4_mispredict_count;

  always #5 clk = ~clk;

  branch_history_table u_dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  branch_history_table #(.CNT_WIDTH(4)) u_dut_c4 (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .pred_taken       (c4_pred_taken),
    .pred_target      (c4_pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .branch_count     (c4_branch_count),
    .mispredict_count (c4_mispredict_count)
  );

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        ump;
    logic [31:0] ipc;
    logic        et;
    logic [31:0] etgt;
  } vec_t;

  vec_t vecs[19];
  vec_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   exp_br = 0;
  int   exp_mp = 0;

  function automatic vec_t mk(logic uv, logic [31:0] upc, logic ut, logic [31:0] utgt,
                              logic ump, logic [31:0] ipc, logic et, logic [31:0] etgt);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.ump = ump; v.ipc = ipc; v.et = et; v.etgt = etgt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
  endtask

  // Drives one cycle of stimulus; the prediction sampled #1 later reflects the
  // table before this cycle's update lands at the next rising edge.
  task automatic drive(input vec_t v, input string name);
    vec_t e;
    @(negedge clk);
    upd_valid      = v.uv;
    upd_pc         = v.upc;
    upd_taken      = v.ut;
    upd_target     = v.utgt;
    upd_mispredict = v.ump;
    if_pc          = v.ipc;
    exp_q.push_back(v);
    if (v.uv) begin
      exp_br++;
      if (v.ump) exp_mp++;
    end
    #1;
    e = exp_q.pop_front();
    check({name, "_taken"}, {31'd0, pred_taken}, {31'd0, e.et});
    check({name, "_target"}, pred_target, e.etgt);
  endtask

  initial begin
    rst = 1'b1;
    if_pc = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
    upd_target = 32'h0; upd_mispredict = 1'b0;

    vecs[0]  = mk(0, 32'h0,   0, 32'h0,    0, 32'h40,  0, 32'h0);
    vecs[1]  = mk(1, 32'h40,  1, 32'h100,  0, 32'h40,  0, 32'h0);
    vecs[2]  = mk(0, 32'h0,   0, 32'h0,    0, 32'h40,  1, 32'h100);
    vecs[3]  = mk(1, 32'h40,  0, 32'h0,    1, 32'h40,  1, 32'h100);
    vecs[4]  = mk(0, 32'h0,   0, 32'h0,    1, 32'h40,  0, 32'h0);
    vecs[5]  = mk(1, 32'h40,  0, 32'h0,    0, 32'h40,  0, 32'h0);
    vecs[6]  = mk(1, 32'h40,  1, 32'h104,  0, 32'h40,  0, 32'h0);
    vecs[7]  = mk(1, 32'h40,  1, 32'h108,  0, 32'h40,  0, 32'h0);
    vecs[8]  = mk(1, 32'h40,  1, 32'h10c,  0, 32'h40,  1, 32'h108);
    vecs[9]  = mk(1, 32'h40,  1, 32'h110,  0, 32'h40,  1, 32'h10c);
    vecs[10] = mk(1, 32'h40,  0, 32'hdead, 0, 32'h40,  1, 32'h110);
    vecs[11] = mk(0, 32'h0,   0, 32'h0,    0, 32'h40,  1, 32'h110);
    vecs[12] = mk(1, 32'h140, 1, 32'h200,  1, 32'h140, 0, 32'h0);
    vecs[13] = mk(0, 32'h0,   0, 32'h0,    0, 32'h40,  0, 32'h0);
    vecs[14] = mk(0, 32'h0,   0, 32'h0,    0, 32'h140, 1, 32'h200);
    vecs[15] = mk(1, 32'h300, 0, 32'h400,  0, 32'h300, 0, 32'h0);
    vecs[16] = mk(0, 32'h0,   0, 32'h0,    0, 32'h300, 0, 32'h0);
    vecs[17] = mk(1, 32'h80,  1, 32'h180,  0, 32'h80,  0, 32'h0);
    vecs[18] = mk(0, 32'h0,   0, 32'h0,    0, 32'h80,  1, 32'h180);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_branch_count", branch_count, 32'd0);
    check("reset_mispredict_count", mispredict_count, 32'd0);

    for (int i = 0; i < 19; i++) drive(vecs[i], $sformatf("vec%0d", i));
    drive(mk(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0), "idle");
    check("table_branch_count", branch_count, 32'(exp_br));
    check("table_mispredict_count", mispredict_count, 32'(exp_mp));

    // Reset asserted alongside a taken update: the update must be dropped.
    @(negedge clk);
    rst = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = 1'b1; upd_target = 32'h700;
    upd_mispredict = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    exp_br = 0; exp_mp = 0;
    if_pc = 32'h300;
    #1;
    check("rst_update_dropped", {31'd0, pred_taken}, 32'd0);
    check("rst_count_zero", branch_count, 32'd0);
    drive(mk(0, 32'h0, 0, 32'h0, 0, 32'h80, 0, 32'h0), "rst_cleared_0x80");

    // Ten not-taken updates with three mispredicts, plus a stray unqualified mispredict.
    for (int i = 0; i < 10; i++)
      drive(mk(1, 32'h500, 0, 32'h0, (i == 1 || i == 4 || i == 7), 32'h500, 0, 32'h0),
            $sformatf("cnt%0d", i));
    drive(mk(0, 32'h500, 0, 32'h0, 1, 32'h500, 0, 32'h0), "cnt_stray_mp");
    check("branch_count_10", branch_count, 32'(exp_br));
    check("mispredict_count_3", mispredict_count, 32'(exp_mp));
    check("c4_branch_count_10", {28'd0, c4_branch_count}, 32'd10);
    check("c4_mispredict_count_3", {28'd0, c4_mispredict_count}, 32'd3);

    for (int i = 0; i < 6; i++)
      drive(mk(1, 32'h500, 0, 32'h0, 0, 32'h500, 0, 32'h0), $sformatf("wrap%0d", i));
    drive(mk(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0), "wrap_idle");
    check("branch_count_16", branch_count, 32'd16);
    check("c4_branch_count_wrap", {28'd0, c4_branch_count}, 32'd0);
    check("c4_mispredict_count_hold", {28'd0, c4_mispredict_count}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
